adc_capture_sequencer: RTL and testbench
========================================

// Module: adc_capture_sequencer
// PURPOSE
//  Parametrised arm/trigger/capture controller in the ADC sample-clock domain; successor to the single-shot armed/capture_go logic.
//  Adds level/edge trigger modes, a glitch filter, post-trigger delay, a programmable capture length and multi-segment re-arm.
//  Emits a gated sample stream (data/valid/OR) plus segment index and trigger timestamp for the downstream DDR/FIFO writer.
// PARAMETERS
//  DATA_WIDTH  10  ADC sample width
//  CNT_WIDTH   32  width of the delay, sample-count and timestamp counters
//  SEG_WIDTH   8   width of the segment count/index
//  FILT_WIDTH  4   width of the trigger glitch-filter length
// PORTS
//  clk_i             in   1           ADC sample clock; the only clock
//  reset_n_i         in   1           synchronous, active-low reset
//  trig_i            in   1           trigger input, already synchronous to clk_i
//  adc_data_i        in   DATA_WIDTH  ADC sample
//  adc_or_i          in   1           ADC over-range flag
//  cfg_arm_i         in   1           arm request; rising edge acts
//  cfg_abort_i       in   1           abort; level, highest priority after reset
//  cfg_mode_i        in   2           00 low-level, 01 high-level, 10 falling-edge, 11 rising-edge
//  cfg_wait_i        in   1           1: trigger must be seen inactive before arming
//  cfg_filter_i      in   FILT_WIDTH  consecutive active cycles required (0 treated as 1)
//  cfg_delay_i       in   CNT_WIDTH   cycles from qualified trigger to first sample
//  cfg_samples_i     in   CNT_WIDTH   samples per segment (0 treated as 1)
//  cfg_segments_i    in   SEG_WIDTH   segments per capture (0 treated as 1)
//  armed_o           out  1           waiting for a qualified trigger
//  capture_go_o      out  1           high from first qualified trigger to end of last segment
//  capture_done_o    out  1           1-cycle pulse when the last segment completes
//  aborted_o         out  1           1-cycle pulse when an abort is taken outside IDLE
//  sample_data_o     out  DATA_WIDTH  registered adc_data_i
//  sample_or_o       out  1           registered adc_or_i
//  sample_valid_o    out  1           sample_data_o belongs to a capture
//  segment_idx_o     out  SEG_WIDTH   current segment index (0-based)
//  trig_ts_o         out  CNT_WIDTH   cycles from arm to the latest qualified trigger
// BEHAVIOUR
//  - Reset (reset_n_i=0 at a clk_i edge): all outputs 0, state IDLE, counters 0, arm edge detector cleared.
//  - All cfg_* inputs are latched on the accepted arm edge; later changes are ignored until the next arm.
//  - Edge modes = the matching level mode with the wait behaviour forced on.
//  - Trigger path: trig_i is registered once into trig_q. Active condition is trig_q==mode[0].
//  - The filter counter counts consecutive active cycles (saturating) and clears on any inactive cycle.
//  - A trigger is qualified on the cycle the filter counter reaches N.
//  - FSM:
//    IDLE -> arm edge -> WAIT_INACT (if wait or edge mode) else ARMED.
//    WAIT_INACT -> first inactive trig_q -> ARMED.
//    ARMED -> qualified trigger -> DELAY (delay>0) or CAPTURE.
//    DELAY -> exactly D cycles -> CAPTURE.
//    CAPTURE: valid for exactly S cycles; then the next segment or DONE.
//    Next segment: segment_idx_o++ -> WAIT_INACT or ARMED, per the arm rule.
//    DONE: capture_done_o pulses for 1 cycle -> IDLE.
//  - armed_o is 1 only in ARMED.
//  - Latency, with N=1 and D=0: trig_i sampled high at edge k -> sample_valid_o first high after edge k+2.
//    Each extra filter cycle and each delay cycle adds exactly 1.
//  - sample_data_o and sample_or_o always track the input with 1-cycle latency; valid gates them.
//  - Timestamp counter clears on arm, increments every cycle, saturates at all-ones; trig_ts_o is latched on each qualified trigger.
//  - Abort (any non-IDLE state) -> IDLE next cycle: capture_go_o=0, valid=0, no done pulse, aborted_o pulse.
//  - Abort wins over a simultaneous arm edge or trigger.
//  - Arm edge while not IDLE: ignored. Re-arming after DONE requires cfg_arm_i to fall and then rise.
//  - Trigger held active across a segment boundary: with wait/edge mode it is not re-qualified until it goes inactive.
//    In pure level mode it re-qualifies after N cycles.
// STRUCTURE
//  - capture_pkg: state encoding (IDLE, WAIT_INACT, ARMED, DELAY, CAPTURE, DONE) and the MODE_* constants.
//  - Sub-module trigger_qualifier holds trig_q, the active-level compare and the filter counter, and outputs active/qualified.
//  - The top holds the FSM, the delay/sample/segment/timestamp counters and the output registers.
// TESTING
//  - Level high, N=1, D=0, S=4, segs=1: trig rises -> valid for 4 cycles starting 2 edges later, done pulse once, go falls with the last valid.
//  - Wait=1 with trig already high at arm: no capture until trig goes low then high; trig_ts_o = cycles from arm to qualification.
//  - Filter N=3: 2-cycle glitch -> no trigger, filter clears; a 3-cycle pulse -> qualifies on its 3rd cycle.
//  - D=5, S=2, segs=3, rising edge: 3 bursts of 2 valid samples, segment_idx_o 0/1/2, each burst 5 cycles after its edge.
//  - Abort mid-CAPTURE at sample 2 of 8: valid drops next cycle, aborted_o pulse, no done, next arm works.
//  - Reset asserted in DELAY: all outputs 0 next edge; arm held high through reset does not arm until it toggles.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared state encoding and trigger-mode constants for the ADC capture sequencer.
package capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_INACT,
    ST_ARMED,
    ST_DELAY,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  localparam logic [1:0] MODE_LOW_LEVEL  = 2'b00;
  localparam logic [1:0] MODE_HIGH_LEVEL = 2'b01;
  localparam logic [1:0] MODE_FALL_EDGE  = 2'b10;
  localparam logic [1:0] MODE_RISE_EDGE  = 2'b11;

  // Edge modes behave as their level counterpart with the wait-for-inactive step forced on.
  function automatic logic mode_is_edge(input logic [1:0] mode);
    return (mode == MODE_FALL_EDGE) || (mode == MODE_RISE_EDGE);
  endfunction

  function automatic logic mode_active_level(input logic [1:0] mode);
    return (mode == MODE_HIGH_LEVEL) || (mode == MODE_RISE_EDGE);
  endfunction

  function automatic logic mode_is_low_level(input logic [1:0] mode);
    return mode == MODE_LOW_LEVEL;
  endfunction

endpackage

// File: rtl/trigger_qualifier.sv
// Registers the trigger once, compares it to the active level and requires N
// consecutive active cycles (counted only while enabled) before qualifying.
module trigger_qualifier #(
  parameter int FILT_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  trig,
  input  logic                  level,
  input  logic [FILT_WIDTH-1:0] filter_len,
  input  logic                  enable,
  output logic                  active,
  output logic                  qualified
);

  logic                  trig_q;
  logic [FILT_WIDTH-1:0] filt_cnt;
  logic [FILT_WIDTH:0]   count_inc;

  assign active    = (trig_q == level);
  assign count_inc = {1'b0, filt_cnt} + {{FILT_WIDTH{1'b0}}, 1'b1};
  // filter_len arrives already normalised to at least 1.
  assign qualified = enable && active && (count_inc == {1'b0, filter_len});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      trig_q   <= 1'b0;
      filt_cnt <= '0;
    end else begin
      trig_q <= trig;
      if (!enable || !active) begin
        filt_cnt <= '0;
      end else if (filt_cnt != '1) begin
        filt_cnt <= count_inc[FILT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/adc_capture_sequencer.sv
// Arm/trigger/capture controller: qualifies a trigger, waits a programmable delay,
// then gates S samples per segment for a programmable number of segments.
module adc_capture_sequencer
  import capture_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int CNT_WIDTH  = 32,
  parameter int SEG_WIDTH  = 8,
  parameter int FILT_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  trig_i,
  input  logic [DATA_WIDTH-1:0] adc_data_i,
  input  logic                  adc_or_i,
  input  logic                  cfg_arm_i,
  input  logic                  cfg_abort_i,
  input  logic [1:0]            cfg_mode_i,
  input  logic                  cfg_wait_i,
  input  logic [FILT_WIDTH-1:0] cfg_filter_i,
  input  logic [CNT_WIDTH-1:0]  cfg_delay_i,
  input  logic [CNT_WIDTH-1:0]  cfg_samples_i,
  input  logic [SEG_WIDTH-1:0]  cfg_segments_i,
  output logic                  armed_o,
  output logic                  capture_go_o,
  output logic                  capture_done_o,
  output logic                  aborted_o,
  output logic [DATA_WIDTH-1:0] sample_data_o,
  output logic                  sample_or_o,
  output logic                  sample_valid_o,
  output logic [SEG_WIDTH-1:0]  segment_idx_o,
  output logic [CNT_WIDTH-1:0]  trig_ts_o
);

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [SEG_WIDTH-1:0]  SEG_ONE  = SEG_WIDTH'(1);
  localparam logic [FILT_WIDTH-1:0] FILT_ONE = FILT_WIDTH'(1);

  state_e                state, state_next;
  logic                  arm_ready;
  logic                  arm_edge, take_arm, take_trig, abort_take;
  logic [1:0]            mode_r;
  logic                  wait_r, wait_eff, wait_arm;
  logic [FILT_WIDTH-1:0] filt_r;
  logic [CNT_WIDTH-1:0]  delay_r, samples_r;
  logic [SEG_WIDTH-1:0]  segs_r;
  logic [CNT_WIDTH-1:0]  cnt, ts_cnt;
  logic [SEG_WIDTH-1:0]  seg_cnt;
  logic                  last_seg;
  logic                  trig_active, trig_qual;

  // arm_ready is cleared by reset, so an arm held high through reset must drop first.
  assign arm_edge   = cfg_arm_i && arm_ready;
  assign abort_take = cfg_abort_i && (state != ST_IDLE);
  assign take_arm   = (state == ST_IDLE) && arm_edge && !cfg_abort_i;
  assign take_trig  = (state == ST_ARMED) && trig_qual && !cfg_abort_i;
  assign wait_arm   = cfg_wait_i || mode_is_edge(cfg_mode_i);
  assign wait_eff   = wait_r || mode_is_edge(mode_r);
  assign last_seg   = (seg_cnt == segs_r - SEG_ONE);

  trigger_qualifier #(
    .FILT_WIDTH(FILT_WIDTH)
  ) u_trig (
    .clk       (clk_i),
    .reset_n   (reset_n_i),
    .trig      (trig_i),
    .level     (!mode_is_low_level(mode_r) && mode_active_level(mode_r)),
    .filter_len(filt_r),
    .enable    (state == ST_ARMED),
    .active    (trig_active),
    .qualified (trig_qual)
  );

  // NOTE: state_next gets its default first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:       if (arm_edge) state_next = wait_arm ? ST_WAIT_INACT : ST_ARMED;
      ST_WAIT_INACT: if (!trig_active) state_next = ST_ARMED;
      ST_ARMED:      if (trig_qual) state_next = (delay_r != '0) ? ST_DELAY : ST_CAPTURE;
      ST_DELAY:      if (cnt == delay_r - CNT_ONE) state_next = ST_CAPTURE;
      ST_CAPTURE: begin
        if (cnt == samples_r - CNT_ONE) begin
          if (last_seg)      state_next = ST_DONE;
          else if (wait_eff) state_next = ST_WAIT_INACT;
          else               state_next = ST_ARMED;
        end
      end
      ST_DONE:       state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
    if (cfg_abort_i) state_next = ST_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state          <= ST_IDLE;
      arm_ready      <= 1'b0;
      mode_r         <= MODE_LOW_LEVEL;
      wait_r         <= 1'b0;
      filt_r         <= FILT_ONE;
      delay_r        <= '0;
      samples_r      <= CNT_ONE;
      segs_r         <= SEG_ONE;
      cnt            <= '0;
      ts_cnt         <= '0;
      seg_cnt        <= '0;
      armed_o        <= 1'b0;
      capture_go_o   <= 1'b0;
      capture_done_o <= 1'b0;
      aborted_o      <= 1'b0;
      sample_data_o  <= '0;
      sample_or_o    <= 1'b0;
      sample_valid_o <= 1'b0;
      segment_idx_o  <= '0;
      trig_ts_o      <= '0;
    end else begin
      state          <= state_next;
      arm_ready      <= !cfg_arm_i;
      cnt            <= (state != state_next) ? '0 : cnt + CNT_ONE;
      ts_cnt         <= (ts_cnt == '1) ? ts_cnt : ts_cnt + CNT_ONE;

      armed_o        <= (state_next == ST_ARMED);
      capture_done_o <= (state == ST_DONE) && !cfg_abort_i;
      aborted_o      <= abort_take;
      sample_data_o  <= adc_data_i;
      sample_or_o    <= adc_or_i;
      sample_valid_o <= (state == ST_CAPTURE) && !cfg_abort_i;
      // Follows seg_cnt one cycle late so the index stays aligned with valid samples.
      segment_idx_o  <= seg_cnt;

      if (take_arm) begin
        mode_r    <= cfg_mode_i;
        wait_r    <= cfg_wait_i;
        filt_r    <= (cfg_filter_i == '0) ? FILT_ONE : cfg_filter_i;
        delay_r   <= cfg_delay_i;
        samples_r <= (cfg_samples_i == '0) ? CNT_ONE : cfg_samples_i;
        segs_r    <= (cfg_segments_i == '0) ? SEG_ONE : cfg_segments_i;
        seg_cnt   <= '0;
        ts_cnt    <= '0;
      end

      if (take_trig) trig_ts_o <= ts_cnt;

      if ((state == ST_CAPTURE) &&
          ((state_next == ST_WAIT_INACT) || (state_next == ST_ARMED))) begin
        seg_cnt <= seg_cnt + SEG_ONE;
      end

      if (abort_take || (state == ST_DONE)) capture_go_o <= 1'b0;
      else if (take_trig)                   capture_go_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed bench for adc_capture_sequencer: a per-cycle vector table for the basic
// capture plus hand-written sequences for wait, filter, multi-segment, abort and reset.
module tb_adc_capture_sequencer;

  localparam int DW = 10;
  localparam int CW = 32;
  localparam int SW = 8;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          trig = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          adc_or = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    cfg_mode = 2'b01;
  logic          cfg_wait = 1'b0;
  logic [FW-1:0] cfg_filter = 4'd1;
  logic [CW-1:0] cfg_delay = '0;
  logic [CW-1:0] cfg_samples = 32'd4;
  logic [SW-1:0] cfg_segments = 8'd1;

  logic          armed_o, capture_go_o, capture_done_o, aborted_o;
  logic [DW-1:0] sample_data_o;
  logic          sample_or_o, sample_valid_o;
  logic [SW-1:0] segment_idx_o;
  logic [CW-1:0] trig_ts_o;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  adc_capture_sequencer #(
    .DATA_WIDTH(DW), .CNT_WIDTH(CW), .SEG_WIDTH(SW), .FILT_WIDTH(FW)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .trig_i        (trig),
    .adc_data_i    (adc_data),
    .adc_or_i      (adc_or),
    .cfg_arm_i     (arm),
    .cfg_abort_i   (abort),
    .cfg_mode_i    (cfg_mode),
    .cfg_wait_i    (cfg_wait),
    .cfg_filter_i  (cfg_filter),
    .cfg_delay_i   (cfg_delay),
    .cfg_samples_i (cfg_samples),
    .cfg_segments_i(cfg_segments),
    .armed_o       (armed_o),
    .capture_go_o  (capture_go_o),
    .capture_done_o(capture_done_o),
    .aborted_o     (aborted_o),
    .sample_data_o (sample_data_o),
    .sample_or_o   (sample_or_o),
    .sample_valid_o(sample_valid_o),
    .segment_idx_o (segment_idx_o),
    .trig_ts_o     (trig_ts_o)
  );

  typedef struct {
    logic          trig;
    logic          arm;
    logic [DW-1:0] data;
    logic          e_armed;
    logic          e_go;
    logic          e_valid;
    logic          e_done;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, want);
  endtask

  // Inputs set here are sampled at the next rising edge; outputs are read 1 time unit later.
  task automatic tick(input logic t, input logic a, input logic ab);
    trig  = t;
    arm   = a;
    abort = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic w, input logic [FW-1:0] f,
                         input logic [CW-1:0] d, input logic [CW-1:0] s, input logic [SW-1:0] g);
    cfg_mode = m; cfg_wait = w; cfg_filter = f;
    cfg_delay = d; cfg_samples = s; cfg_segments = g;
  endtask

  task automatic wait_armed(input string name);
    int n = 0;
    while (!armed_o && n < 20) begin
      tick(1'b0, 1'b0, 1'b0);
      n++;
    end
    check(name, armed_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int done_cnt;

    vecs[0] = '{1'b0, 1'b1, 10'h101, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 10'h102, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 10'h103, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 10'h104, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 10'h105, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 10'h106, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 10'h107, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 10'h108, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 10'h109, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 10'h10A, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset with live inputs: every output must read zero.
    reset_n = 1'b0; adc_data = 10'h155; adc_or = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check("rst_data", sample_data_o, 0);
    check("rst_or", sample_or_o, 0);
    check("rst_armed", armed_o, 0);
    check("rst_go", capture_go_o, 0);
    check("rst_valid", sample_valid_o, 0);
    check("rst_done", capture_done_o, 0);
    check("rst_aborted", aborted_o, 0);
    check("rst_idx", segment_idx_o, 0);
    check("rst_ts", trig_ts_o, 0);
    reset_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    check("data_track", sample_data_o, 10'h155);
    check("or_track", sample_or_o, 1);
    adc_or = 1'b0;
    tick(1'b0, 1'b0, 1'b0);

    // Level high, N=1, D=0, S=4, one segment; samples cfg changes after arm and must be ignored.
    set_cfg(2'b01, 1'b0, 4'd1, 32'd0, 32'd4, 8'd1);
    for (int i = 0; i < 10; i++) begin
      cfg_samples = (i == 0) ? 32'd4 : 32'd1;
      adc_data = vecs[i].data;
      tick(vecs[i].trig, vecs[i].arm, 1'b0);
      check($sformatf("tbl%0d_armed", i), armed_o, vecs[i].e_armed);
      check($sformatf("tbl%0d_go", i), capture_go_o, vecs[i].e_go);
      check($sformatf("tbl%0d_valid", i), sample_valid_o, vecs[i].e_valid);
      check($sformatf("tbl%0d_done", i), capture_done_o, vecs[i].e_done);
      check($sformatf("tbl%0d_data", i), sample_data_o, vecs[i].data);
    end
    check("tbl_ts", trig_ts_o, 2);
    check("tbl_idx", segment_idx_o, 0);

    // Wait mode with trigger already high at arm.
    set_cfg(2'b01, 1'b1, 4'd1, 32'd0, 32'd2, 8'd1);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("wait_not_armed", armed_o, 0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check("wait_hold_armed", armed_o, 0);
    check("wait_hold_go", capture_go_o, 0);
    tick(1'b0, 1'b0, 1'b0);
    check("wait_low_armed", armed_o, 0);
    tick(1'b1, 1'b0, 1'b0);
    check("wait_armed", armed_o, 1);
    tick(1'b1, 1'b0, 1'b0);
    check("wait_go", capture_go_o, 1);
    check("wait_ts", trig_ts_o, 4);
    tick(1'b1, 1'b0, 1'b0);
    check("wait_valid0", sample_valid_o, 1);
    tick(1'b1, 1'b0, 1'b0);
    check("wait_valid1", sample_valid_o, 1);
    tick(1'b1, 1'b0, 1'b0);
    check("wait_done", capture_done_o, 1);
    check("wait_valid_end", sample_valid_o, 0);

    // Filter N=3: 2-cycle glitch rejected, 3-cycle pulse qualifies on its third cycle.
    set_cfg(2'b01, 1'b0, 4'd3, 32'd0, 32'd1, 8'd1);
    tick(1'b0, 1'b1, 1'b0);
    check("filt_armed", armed_o, 1);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("glitch_armed", armed_o, 1);
    check("glitch_go", capture_go_o, 0);
    tick(1'b1, 1'b0, 1'b0);
    check("pulse_c1_go", capture_go_o, 0);
    tick(1'b1, 1'b0, 1'b0);
    check("pulse_c2_go", capture_go_o, 0);
    tick(1'b1, 1'b0, 1'b0);
    check("pulse_c3_armed", armed_o, 1);
    check("pulse_c3_go", capture_go_o, 0);
    tick(1'b0, 1'b0, 1'b0);
    check("pulse_go", capture_go_o, 1);
    check("pulse_armed", armed_o, 0);
    tick(1'b0, 1'b0, 1'b0);
    check("pulse_valid", sample_valid_o, 1);
    tick(1'b0, 1'b0, 1'b0);
    check("pulse_done", capture_done_o, 1);

    // Rising edge, D=5, S=2, three segments; trigger held high past each burst.
    set_cfg(2'b11, 1'b0, 4'd1, 32'd5, 32'd2, 8'd3);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      wait_armed($sformatf("seg%0d_armed", s));
      tick(1'b1, 1'b0, 1'b0);
      for (int j = 1; j <= 10; j++) begin
        tick(1'b1, 1'b0, 1'b0);
        check($sformatf("seg%0d_j%0d_valid", s, j), sample_valid_o, (j == 7 || j == 8) ? 1 : 0);
        check($sformatf("seg%0d_j%0d_done", s, j), capture_done_o, (j == 9 && s == 2) ? 1 : 0);
        check($sformatf("seg%0d_j%0d_go", s, j), capture_go_o, (j <= 8 || s != 2) ? 1 : 0);
        if (j == 7) check($sformatf("seg%0d_idx", s), segment_idx_o, s);
        if (j >= 9) check($sformatf("seg%0d_j%0d_noarm", s, j), armed_o, 0);
      end
    end
    tick(1'b0, 1'b0, 1'b0);

    // Abort at sample 2 of 8, then abort versus arm in IDLE, then a fresh arm.
    set_cfg(2'b01, 1'b0, 4'd1, 32'd0, 32'd8, 8'd1);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check("abt_armed", armed_o, 1);
    tick(1'b1, 1'b0, 1'b0);
    check("abt_go", capture_go_o, 1);
    tick(1'b1, 1'b0, 1'b0);
    check("abt_s1", sample_valid_o, 1);
    tick(1'b1, 1'b0, 1'b0);
    check("abt_s2", sample_valid_o, 1);
    tick(1'b1, 1'b0, 1'b1);
    check("abt_valid", sample_valid_o, 0);
    check("abt_go_low", capture_go_o, 0);
    check("abt_pulse", aborted_o, 1);
    tick(1'b1, 1'b0, 1'b0);
    check("abt_pulse_end", aborted_o, 0);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (capture_done_o) done_cnt++;
    end
    check("abt_no_done", done_cnt, 0);
    tick(1'b1, 1'b1, 1'b1);
    check("abt_beats_arm", armed_o, 0);
    check("abt_idle_nopulse", aborted_o, 0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("rearm_armed", armed_o, 1);
    tick(1'b1, 1'b0, 1'b0);
    check("rearm_go", capture_go_o, 1);
    tick(1'b1, 1'b0, 1'b0);
    check("rearm_valid", sample_valid_o, 1);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);

    // Reset during DELAY with arm held high through and after reset.
    set_cfg(2'b01, 1'b0, 4'd1, 32'd5, 32'd2, 8'd1);
    tick(1'b1, 1'b1, 1'b0);
    check("dly_armed", armed_o, 1);
    tick(1'b1, 1'b1, 1'b0);
    check("dly_go", capture_go_o, 1);
    tick(1'b1, 1'b1, 1'b0);
    reset_n = 1'b0; adc_data = 10'h3FF; adc_or = 1'b1;
    tick(1'b1, 1'b1, 1'b0);
    check("dly_rst_go", capture_go_o, 0);
    check("dly_rst_data", sample_data_o, 0);
    check("dly_rst_or", sample_or_o, 0);
    check("dly_rst_armed", armed_o, 0);
    check("dly_rst_valid", sample_valid_o, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      check($sformatf("held_arm%0d_armed", i), armed_o, 0);
      check($sformatf("held_arm%0d_go", i), capture_go_o, 0);
    end
    check("post_rst_data", sample_data_o, 10'h3FF);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("toggle_arm", armed_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
